tkr_readout_sequencer: RTL and testbench
========================================

# tkr_readout_sequencer

Event readout sequencer for the 6-chip tracker board. It counts accepted triggers and, for each pending event, grants the shared event-builder datapath to front-end chips 0..5 in fixed order. For every chip it waits for that chip's event to be ready, holds the grant until the chip's dump completes, and applies a timeout to both waits. It sits inside the tracker DAQ logic, between the per-chip serial receivers and the output event builder that drives Dout.

## Interface
Parameters:
- NCHIP, 6, number of front-end chips served.
- TO_CYC, 1023, timeout in CLK cycles for both the ready wait and the transfer wait (10 bits).
- QDEPTH, 4, maximum number of pending events.

Ports:
- CLK  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- TrgAcc  in  1  one-cycle pulse: a trigger was accepted.
- OutRdy  in  1  event builder can start a new event.
- ChipRdy  in  NCHIP  chip i has its event header buffered.
- ChipDone  in  NCHIP  one-cycle pulse: chip i finished its dump.
- Grant  out  NCHIP  one-hot grant of the datapath to chip i.
- EvtStart  out  1  one-cycle pulse: a new event begins.
- EvtDone  out  1  one-cycle pulse: the event is complete.
- EvtTag  out  2  event tag; valid while Busy.
- MissMask  out  NCHIP  chips that timed out; valid during EvtDone.
- Pending  out  3  number of queued events, 0..QDEPTH.
- Busy  out  1  sequencer is not in IDLE.
- Overflow  out  1  one-cycle pulse: a trigger was dropped because the queue was full.

## Operation
- Pending counter:
  - +1 on TrgAcc; −1 in the EvtDone cycle.
  - Both in the same cycle: Pending is unchanged.
  - TrgAcc with Pending==QDEPTH and no simultaneous EvtDone: no increment; Overflow pulses.
- States:
  - IDLE: when Pending>0, go to HDR.
  - HDR: wait for OutRdy; then pulse EvtStart, set ptr=0, clear MissMask and the timer, go to WAIT.
  - WAIT: ChipRdy[ptr]=1 → XFER, timer cleared. Timer reaching TO_CYC → set MissMask[ptr], go to NEXT.
  - XFER: Grant[ptr]=1. ChipDone[ptr] → NEXT. Timer reaching TO_CYC → set MissMask[ptr], go to NEXT.
  - NEXT: if ptr==NCHIP−1, go to TRL; else ptr+1, timer cleared, go to WAIT.
  - TRL: pulse EvtDone, EvtTag+1 (wraps modulo 4), Pending−1, go to IDLE.
- ChipDone for any chip other than ptr, or outside XFER, is ignored.
- ChipRdy is sampled only in WAIT and only for chip ptr.
- Reset mid-event: the state machine returns to IDLE, Pending=0 and the queued events are discarded, Grant is dropped in the next cycle, and no EvtDone is generated.

## Timing
- Reset values (all outputs, the cycle after Reset is sampled high): Grant=0, EvtStart=0, EvtDone=0, EvtTag=0, MissMask=0, Pending=0, Busy=0, Overflow=0.
- All outputs are registered.
- Pending updates in the cycle after the TrgAcc edge.
- IDLE→HDR takes 1 cycle. With OutRdy already high, EvtStart is high 2 cycles after Pending becomes nonzero.
- ChipRdy[ptr] sampled high at edge n → Grant[ptr] high from n+1.
- ChipDone[ptr] sampled at edge m → Grant low at m+1 (NEXT), and the next chip is in WAIT at m+2.
- The timer counts from 0 on state entry. The timeout fires at the edge where the count equals TO_CYC, i.e. TO_CYC+1 cycles after entry.
- Minimum event duration, all chips ready and ChipDone arriving 1 cycle after Grant: HDR 1 + 6×(WAIT 1 + XFER 2 + NEXT 1) + TRL 1 = 26 cycles.
- Grant is never high for two chips in the same cycle and is never high outside XFER.

## Structure
- Shared tracker package holds:
  - the state enum (IDLE, HDR, WAIT, XFER, NEXT, TRL);
  - NCHIP, TO_CYC and QDEPTH defaults;
  - the EvtTag width.
- One sub-module: tkr_timeout_timer, a 10-bit counter with clear, enable and an expired flag, instanced once and shared by WAIT and XFER.
- Everything else is flat in tkr_readout_sequencer.

## Test plan
- Nominal event: 1 TrgAcc; ChipRdy=6'h3F and OutRdy=1; ChipDone[i] pulsed 3 cycles after each Grant[i] → Grant walks 01,02,04,08,10,20; EvtDone with MissMask=0; EvtTag goes 0→1; Pending goes 1→0.
- Ready timeout: ChipRdy[3] held 0 → after TO_CYC+1 cycles in WAIT the sequencer moves on to chip 4; Grant[3] never asserts; EvtDone carries MissMask=6'h08.
- Transfer timeout: ChipDone[5] is never sent → Grant[5] is held for TO_CYC+1 cycles then drops; MissMask=6'h20.
- Queue full: 5 TrgAcc pulses with OutRdy=0 → Pending=4, exactly 1 Overflow pulse. Then TrgAcc coincident with EvtDone → Pending stays at its value.
- Back-to-back events: 3 TrgAcc pulses → 3 EvtStart/EvtDone pairs; EvtTag 0,1,2; no Grant overlap. A stray ChipDone[2] while chip 0 is granted is ignored.
- Reset while Grant[2] is high → Grant=0, Pending=0, Busy=0 the next cycle; no EvtDone is emitted.

Source files
------------

// File: rtl/tkr_readout_sequencer_pkg.sv
// Shared tracker definitions: FSM state codes, default sizing and field widths.
package tkr_readout_sequencer_pkg;

    localparam int unsigned NCHIP_DEF  = 6;
    localparam int unsigned TO_CYC_DEF = 1023;
    localparam int unsigned QDEPTH_DEF = 4;

    localparam int unsigned TMR_W  = 10;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned PEND_W = 3;
    localparam int unsigned ST_W   = 3;

    // Sequencer states
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_HDR  = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_XFER = 3'd3;
    localparam logic [ST_W-1:0] ST_NEXT = 3'd4;
    localparam logic [ST_W-1:0] ST_TRL  = 3'd5;

    typedef logic [TAG_W-1:0] evt_tag_t;

endpackage

// File: rtl/tkr_timeout_timer.sv
// Shared wait/transfer timeout counter: counts from 0 after clear, flags when TO_CYC is reached.
module tkr_timeout_timer
    import tkr_readout_sequencer_pkg::*;
#(
    parameter int unsigned TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign expired_c = (cnt_q == TMR_W'(TO_CYC));

    // Next count: clear wins, otherwise count up and hold once expired
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired_c) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tkr_readout_sequencer.sv
// Tracker event readout sequencer: queues triggers and walks the datapath grant over all chips per event.
module tkr_readout_sequencer
    import tkr_readout_sequencer_pkg::*;
#(
    parameter int unsigned NCHIP  = NCHIP_DEF,
    parameter int unsigned TO_CYC = TO_CYC_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              TrgAcc,
    input  logic              OutRdy,
    input  logic [NCHIP-1:0]  ChipRdy,
    input  logic [NCHIP-1:0]  ChipDone,
    output logic [NCHIP-1:0]  Grant,
    output logic              EvtStart,
    output logic              EvtDone,
    output logic [TAG_W-1:0]  EvtTag,
    output logic [NCHIP-1:0]  MissMask,
    output logic [PEND_W-1:0] Pending,
    output logic              Busy,
    output logic              Overflow
);

    localparam int unsigned PTR_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NCHIP-1:0]  miss_q, miss_d;
    logic [NCHIP-1:0]  grant_q, grant_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    evt_tag_t          tag_q, tag_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_exp_c;
    logic              trl_c;

    // One timer serves both the ready wait and the transfer wait
    tkr_timeout_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk       (CLK),
        .rst       (Reset),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .expired_c (tmr_exp_c)
    );

    assign tmr_en = (state_q == ST_WAIT) || (state_q == ST_XFER);
    assign trl_c  = (state_q == ST_TRL);

    // Next-state logic; any state change restarts the timer so it counts from 0 on entry
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        miss_d  = miss_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (OutRdy) begin
                    state_d = ST_WAIT;
                    ptr_d   = '0;
                    miss_d  = '0;
                end
            end
            ST_WAIT: begin
                if (ChipRdy[ptr_q]) begin
                    state_d = ST_XFER;
                end else if (tmr_exp_c) begin
                    miss_d[ptr_q] = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_XFER: begin
                if (ChipDone[ptr_q]) begin
                    state_d = ST_NEXT;
                end else if (tmr_exp_c) begin
                    miss_d[ptr_q] = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (ptr_q == PTR_W'(NCHIP - 1)) begin
                    state_d = ST_TRL;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_TRL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tmr_clr = (state_d != state_q);
    end

    // Pending queue, tag and registered output pulses, all aligned with the next state
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (TrgAcc && !trl_c) begin
            if (pend_q == PEND_W'(QDEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!TrgAcc && trl_c) begin
            pend_d = pend_q - PEND_W'(1);
        end

        tag_d = trl_c ? tag_q + TAG_W'(1) : tag_q;

        grant_d = '0;
        if (state_d == ST_XFER) begin
            grant_d[ptr_d] = 1'b1;
        end

        start_d = (state_q == ST_HDR) && OutRdy;
        done_d  = (state_d == ST_TRL);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            miss_q  <= '0;
            grant_q <= '0;
            pend_q  <= '0;
            tag_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            miss_q  <= miss_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Grant    = grant_q;
    assign EvtStart = start_q;
    assign EvtDone  = done_q;
    assign EvtTag   = tag_q;
    assign MissMask = miss_q;
    assign Pending  = pend_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_tkr_readout_sequencer.sv
// Scoreboard bench for the tracker readout sequencer with a per-event behavioural model.
module tb_tkr_readout_sequencer;

    localparam int unsigned NCHIP  = 6;
    localparam int unsigned TO_CYC = 1023;
    localparam int unsigned QDEPTH = 4;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             TrgAcc;
    logic             OutRdy;
    logic [NCHIP-1:0] ChipRdy;
    logic [NCHIP-1:0] ChipDone;
    logic [NCHIP-1:0] Grant;
    logic             EvtStart;
    logic             EvtDone;
    logic [1:0]       EvtTag;
    logic [NCHIP-1:0] MissMask;
    logic [2:0]       Pending;
    logic             Busy;
    logic             Overflow;

    always #5 CLK = ~CLK;

    tkr_readout_sequencer #(
        .NCHIP  (NCHIP),
        .TO_CYC (TO_CYC),
        .QDEPTH (QDEPTH)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .TrgAcc   (TrgAcc),
        .OutRdy   (OutRdy),
        .ChipRdy  (ChipRdy),
        .ChipDone (ChipDone),
        .Grant    (Grant),
        .EvtStart (EvtStart),
        .EvtDone  (EvtDone),
        .EvtTag   (EvtTag),
        .MissMask (MissMask),
        .Pending  (Pending),
        .Busy     (Busy),
        .Overflow (Overflow)
    );

    // Chip behaviour for one event: rdy=0 means never ready, dly=0 means never finishes
    typedef struct packed {
        logic [NCHIP-1:0]      rdy;
        logic [NCHIP-1:0][3:0] dly;
    } cfg_t;

    typedef struct packed {
        logic [1:0]             tag;
        logic [NCHIP-1:0]       miss;
        logic [NCHIP-1:0][10:0] glen;
        logic [31:0]            dur;
    } exp_t;

    cfg_t        cfg_q[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned acc_cnt = 0;
    int unsigned model_pend = 0;
    int          exp_ovf = 0;
    int          ovf_seen = 0;
    int          cyc = 0;
    logic        stray_en = 1'b0;
    logic        stray_fixed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one event: a chip is missed if it never gets ready or never finishes;
    // each chip costs its ready wait + its transfer + one step cycle.
    function automatic exp_t predict(input cfg_t c, input logic [1:0] tag);
        exp_t        e;
        int unsigned w;
        int unsigned x;
        e.tag  = tag;
        e.miss = '0;
        e.glen = '0;
        e.dur  = '0;
        for (int i = 0; i < NCHIP; i++) begin
            if (!c.rdy[i]) begin
                w = TO_CYC + 1;
                x = 0;
                e.miss[i] = 1'b1;
            end else begin
                w = 1;
                if (c.dly[i] == 4'd0) begin
                    x = TO_CYC + 1;
                    e.miss[i] = 1'b1;
                end else begin
                    x = c.dly[i];
                end
            end
            e.glen[i] = 11'(x);
            e.dur     = e.dur + 32'(w + x + 1);
        end
        return e;
    endfunction

    function automatic cfg_t full_cfg(input int unsigned d);
        cfg_t c;
        c.rdy = '1;
        for (int i = 0; i < NCHIP; i++) c.dly[i] = 4'(d);
        return c;
    endfunction

    function automatic cfg_t rand_cfg(input bit allow_to);
        cfg_t c;
        for (int i = 0; i < NCHIP; i++) begin
            c.rdy[i] = !(allow_to && ($urandom_range(0, 23) == 0));
            c.dly[i] = (allow_to && ($urandom_range(0, 23) == 0)) ? 4'd0 : 4'($urandom_range(1, 5));
        end
        return c;
    endfunction

    task automatic enqueue(input cfg_t c);
        cfg_q.push_back(c);
        exp_q.push_back(predict(c, 2'(acc_cnt)));
        acc_cnt++;
    endtask

    // One TrgAcc pulse, driven from a falling edge
    task automatic issue(input cfg_t c);
        TrgAcc = 1'b1;
        if (model_pend < QDEPTH) begin
            enqueue(c);
            model_pend++;
        end else begin
            exp_ovf++;
        end
        @(negedge CLK);
        TrgAcc = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 40000; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !Busy && Pending == 3'd0) break;
        end
        checks++;
        if (k >= 40000) begin
            errors++;
            $display("FAIL drain: timed out with %0d events outstanding", exp_q.size());
        end
    endtask

    // Chip responder: applies the current event's ready pattern and finishes each granted chip on time
    initial begin
        cfg_t cur;
        int   gcnt [NCHIP];
        int   j;
        cur      = '0;
        ChipRdy  = '0;
        ChipDone = '0;
        for (int i = 0; i < NCHIP; i++) gcnt[i] = 0;
        forever begin
            @(posedge CLK);
            #1;
            ChipDone = '0;
            if (EvtStart) begin
                if (cfg_q.size() > 0) begin
                    cur = cfg_q.pop_front();
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL evt_start: EvtStart with no queued trigger");
                end
                ChipRdy = cur.rdy;
            end
            for (int i = 0; i < NCHIP; i++) begin
                if (Grant[i]) begin
                    gcnt[i]++;
                    if (cur.dly[i] != 4'd0 && gcnt[i] == int'(cur.dly[i])) ChipDone[i] = 1'b1;
                end else begin
                    gcnt[i] = 0;
                end
            end
            if (stray_en && Grant != '0 && $urandom_range(0, 2) == 0) begin
                j = int'($urandom_range(0, NCHIP - 1));
                if (!Grant[j]) ChipDone[j] = 1'b1;
            end
            if (stray_fixed && Grant[0]) ChipDone[2] = 1'b1;
        end
    end

    // Monitor: tracks grants per event and scores each EvtDone against the queued expectation
    initial begin
        logic [NCHIP-1:0][10:0] glen;
        int   start_cyc;
        int   viol;
        exp_t e;
        glen      = '0;
        start_cyc = 0;
        viol      = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (Reset) begin
                glen = '0;
                viol = 0;
            end else begin
                if (Overflow) ovf_seen++;
                if ($countones(Grant) > 1 || (Grant != '0 && !Busy)) viol++;
                if (EvtStart) begin
                    start_cyc = cyc;
                    glen      = '0;
                    viol      = 0;
                end
                for (int i = 0; i < NCHIP; i++) begin
                    if (Grant[i]) glen[i] = glen[i] + 11'd1;
                end
                if (EvtDone) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL evt_done: unexpected EvtDone tag=%0d", EvtTag);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_tag", 32'(EvtTag), 32'(e.tag));
                        check("miss_mask", 32'(MissMask), 32'(e.miss));
                        check("evt_duration", 32'(cyc - start_cyc), e.dur);
                        check("grant_overlap", 32'(viol), 32'd0);
                        check("busy_at_done", 32'(Busy), 32'd1);
                        for (int i = 0; i < NCHIP; i++) begin
                            check($sformatf("grant_len_chip%0d", i), 32'(glen[i]), 32'(e.glen[i]));
                        end
                        if (model_pend > 0) model_pend--;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus
    initial begin
        cfg_t c;
        int   k;
        Reset  = 1'b1;
        TrgAcc = 1'b0;
        OutRdy = 1'b1;
        @(negedge CLK);
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_evtstart", 32'(EvtStart), 32'd0);
        check("rst_evtdone", 32'(EvtDone), 32'd0);
        check("rst_evttag", 32'(EvtTag), 32'd0);
        check("rst_missmask", 32'(MissMask), 32'd0);
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Nominal event with start latency
        TrgAcc = 1'b1;
        enqueue(full_cfg(4));
        model_pend++;
        @(negedge CLK);
        TrgAcc = 1'b0;
        check("pending_after_trg", 32'(Pending), 32'd1);
        check("evtstart_early", 32'(EvtStart), 32'd0);
        @(negedge CLK);
        check("evtstart_in_hdr", 32'(EvtStart), 32'd0);
        check("busy_in_hdr", 32'(Busy), 32'd1);
        @(negedge CLK);
        check("evtstart_latency", 32'(EvtStart), 32'd1);
        drain();
        check("nominal_pending_end", 32'(Pending), 32'd0);
        check("nominal_tag_end", 32'(EvtTag), 32'd1);

        // Minimum-length event
        issue(full_cfg(2));
        drain();

        // Ready timeout on chip 3
        c = full_cfg(3);
        c.rdy[3] = 1'b0;
        issue(c);
        drain();

        // Transfer timeout on chip 5
        c = full_cfg(3);
        c.dly[5] = 4'd0;
        issue(c);
        drain();

        // Queue full, then a trigger coincident with EvtDone
        OutRdy = 1'b0;
        for (int i = 0; i < 5; i++) issue(full_cfg(1));
        check("queue_full_pending", 32'(Pending), 32'd4);
        @(negedge CLK);
        check("overflow_count", 32'(ovf_seen), 32'(exp_ovf));
        check("overflow_once", 32'(ovf_seen), 32'd1);
        OutRdy = 1'b1;
        for (k = 0; k < 5000; k++) begin
            if (EvtDone) break;
            @(negedge CLK);
        end
        check("evtdone_seen", 32'(k < 5000), 32'd1);
        TrgAcc = 1'b1;
        enqueue(full_cfg(2));
        @(negedge CLK);
        TrgAcc = 1'b0;
        check("coincident_pending", 32'(Pending), 32'd4);
        @(negedge CLK);
        check("coincident_no_overflow", 32'(ovf_seen), 32'd1);
        drain();

        // Reset while chip 2 holds the grant
        c = full_cfg(3);
        c.dly[2] = 4'd0;
        issue(c);
        issue(full_cfg(3));
        for (k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if (Grant[2]) break;
        end
        check("grant2_seen", 32'(k < 3000), 32'd1);
        Reset = 1'b1;
        cfg_q.delete();
        exp_q.delete();
        model_pend = 0;
        acc_cnt    = 0;
        @(negedge CLK);
        check("midrst_grant", 32'(Grant), 32'd0);
        check("midrst_pending", 32'(Pending), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_evtdone", 32'(EvtDone), 32'd0);
        Reset = 1'b0;
        repeat (100) @(negedge CLK);
        check("post_rst_idle", 32'(Busy), 32'd0);

        // Back-to-back events with stray ChipDone pulses
        stray_en    = 1'b1;
        stray_fixed = 1'b1;
        for (int i = 0; i < 3; i++) issue(rand_cfg(1'b0));
        drain();
        stray_fixed = 1'b0;

        // Random traffic
        for (int n = 0; n < 12; ) begin
            OutRdy = ($urandom_range(0, 3) != 0);
            if (model_pend <= 2 && $urandom_range(0, 3) == 0) begin
                issue(rand_cfg(1'b1));
                n++;
            end else begin
                @(negedge CLK);
            end
        end
        OutRdy = 1'b1;
        drain();
        stray_en = 1'b0;
        check("final_overflow_count", 32'(ovf_seen), 32'(exp_ovf));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
